// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared encodings for the multi-cycle control path.
//   - FSM state encoding (also exported on the debug bus)
//   - RV32I opcode constants for the supported subset
//   - ALU function codes, pc_src / wb_sel / trap_cause codes
//   - opcode_legal(): membership test for the supported opcode set
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_e;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;
  localparam logic [1:0] WB_IMM  = 2'd3;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  function automatic logic opcode_legal(input logic [6:0] opc);
    case (opc)
      OPC_R, OPC_IALU, OPC_LOAD, OPC_STORE,
      OPC_BRANCH, OPC_JAL, OPC_LUI: opcode_legal = 1'b1;
      default:                      opcode_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_unit_alu_op_decode.sv
// alu_op_decode: combinational opcode/funct3/funct7b5 -> ALU function.
//   opcode_i   : registered instr[6:0]
//   funct3_i   : registered instr[14:12]
//   funct7b5_i : registered instr[30]
//   alu_op_o   : ALU function code (cpu_ctrl_pkg::alu_op_e)
module alu_op_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output logic [3:0] alu_op_o
);

  always_comb begin
    alu_op_o = ALU_ADD;
    case (opcode_i)
      OPC_R, OPC_IALU: begin
        case (funct3_i)
          // ADDI has no SUB form: bit 30 is part of the immediate there
          3'b000:  alu_op_o = (opcode_i == OPC_R && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_op_o = ALU_SLL;
          3'b010:  alu_op_o = ALU_SLT;
          3'b011:  alu_op_o = ALU_SLTU;
          3'b100:  alu_op_o = ALU_XOR;
          3'b101:  alu_op_o = funct7b5_i ? ALU_SRA : ALU_SRL;
          3'b110:  alu_op_o = ALU_OR;
          default: alu_op_o = ALU_AND;
        endcase
      end
      OPC_BRANCH: begin
        case (funct3_i[2:1])
          2'b10:   alu_op_o = ALU_SLT;
          2'b11:   alu_op_o = ALU_SLTU;
          default: alu_op_o = ALU_SUB;
        endcase
      end
      default: alu_op_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_unit.sv
// multicycle_ctrl_unit: FETCH/DECODE/EXEC/MEM/WB sequencer sharing one
// memory port, with ready handshake + bus timeout, illegal-opcode trap and
// a retired-instruction counter.
//   clk, reset                : clock, synchronous active-high reset
//   opcode, funct3, funct7b5  : instruction fields (captured in DECODE)
//   br_taken                  : branch condition during EXEC
//   mem_ready                 : memory completes current request
//   mem_req/mem_we/addr_sel   : memory port control
//   ir_we/pc_we/pc_src        : IR and PC update control
//   alu_op/alu_src            : ALU control
//   reg_wr/wb_sel             : register write-back control
//   state_o/instret/trap/trap_cause : status and debug
module multicycle_ctrl_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned ALU_OP_W    = 4,
  parameter int unsigned TIMEOUT_W   = 8,
  parameter int unsigned TIMEOUT_MAX = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic                funct7b5,
  input  logic                br_taken,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                addr_sel,
  output logic                ir_we,
  output logic                pc_we,
  output logic [1:0]          pc_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_src,
  output logic                reg_wr,
  output logic [1:0]          wb_sel,
  output logic [2:0]          state_o,
  output logic [CNT_W-1:0]    instret,
  output logic                trap,
  output logic [1:0]          trap_cause
);

  localparam logic [TIMEOUT_W-1:0] WAIT_LIMIT = TIMEOUT_W'(TIMEOUT_MAX - 1);

  state_e               state_q, state_d;
  logic [6:0]           opc_q, opc_d;
  logic [2:0]           f3_q, f3_d;
  logic                 f7b5_q, f7b5_d;
  logic [TIMEOUT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]     instret_q, instret_d;
  logic                 trap_q, trap_d;
  logic [1:0]           cause_q, cause_d;

  logic [3:0] dec_op;
  logic       req_s, we_s, irwe_s, pcwe_s, regwr_s;
  logic       hs, timeout_hit;

  alu_op_decode u_alu_op_decode (
    .opcode_i   (opc_q),
    .funct3_i   (f3_q),
    .funct7b5_i (f7b5_q),
    .alu_op_o   (dec_op)
  );

  // Request is a pure function of state, so the handshake and the timeout
  // decision can be resolved once, ahead of the per-state logic.
  assign req_s       = (state_q == FETCH) || (state_q == MEM);
  assign hs          = req_s && mem_ready;
  assign timeout_hit = req_s && !mem_ready && (wait_q == WAIT_LIMIT);

  always_comb begin
    state_d   = state_q;
    opc_d     = opc_q;
    f3_d      = f3_q;
    f7b5_d    = f7b5_q;
    instret_d = instret_q;
    trap_d    = trap_q;
    cause_d   = cause_q;
    wait_d    = hs ? '0 : (req_s ? wait_q + TIMEOUT_W'(1) : wait_q);

    we_s     = 1'b0;
    irwe_s   = 1'b0;
    pcwe_s   = 1'b0;
    regwr_s  = 1'b0;
    addr_sel = 1'b0;
    pc_src   = PC_PLUS4;
    alu_op   = '0;
    alu_src  = 1'b0;
    wb_sel   = WB_ALU;

    case (state_q)
      FETCH: begin
        if (hs) begin
          irwe_s  = 1'b1;
          pcwe_s  = 1'b1;
          state_d = DECODE;
        end else if (timeout_hit) begin
          state_d = TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      DECODE: begin
        opc_d  = opcode;
        f3_d   = funct3;
        f7b5_d = funct7b5;
        if (opcode_legal(opcode)) begin
          state_d = EXEC;
        end else begin
          state_d = TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      EXEC: begin
        alu_op = ALU_OP_W'(dec_op);
        case (opc_q)
          OPC_R:    state_d = WB;
          OPC_IALU: begin alu_src = 1'b1; state_d = WB;  end
          OPC_LOAD,
          OPC_STORE: begin alu_src = 1'b1; state_d = MEM; end
          OPC_BRANCH: begin
            if (br_taken) begin
              pcwe_s = 1'b1;
              pc_src = PC_BRANCH;
            end
            instret_d = instret_q + CNT_W'(1);
            state_d   = FETCH;
          end
          OPC_JAL: begin
            pcwe_s  = 1'b1;
            pc_src  = PC_JUMP;
            state_d = WB;
          end
          OPC_LUI: state_d = WB;
          default: begin
            state_d = TRAP;
            trap_d  = 1'b1;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      MEM: begin
        addr_sel = 1'b1;
        we_s     = (opc_q == OPC_STORE);
        if (hs) begin
          if (opc_q == OPC_STORE) begin
            instret_d = instret_q + CNT_W'(1);
            state_d   = FETCH;
          end else begin
            state_d = WB;
          end
        end else if (timeout_hit) begin
          state_d = TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      WB: begin
        regwr_s = 1'b1;
        case (opc_q)
          OPC_LOAD: wb_sel = WB_MEM;
          OPC_JAL:  wb_sel = WB_PC4;
          OPC_LUI:  wb_sel = WB_IMM;
          default:  wb_sel = WB_ALU;
        endcase
        instret_d = instret_q + CNT_W'(1);
        state_d   = FETCH;
      end
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      opc_q     <= '0;
      f3_q      <= '0;
      f7b5_q    <= 1'b0;
      wait_q    <= '0;
      instret_q <= '0;
      trap_q    <= 1'b0;
      cause_q   <= CAUSE_NONE;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      f3_q      <= f3_d;
      f7b5_q    <= f7b5_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
    end
  end

  // Strobes are forced low while reset is held, independent of state.
  assign mem_req    = req_s   & ~reset;
  assign mem_we     = we_s    & ~reset;
  assign ir_we      = irwe_s  & ~reset;
  assign pc_we      = pcwe_s  & ~reset;
  assign reg_wr     = regwr_s & ~reset;
  assign state_o    = state_q;
  assign instret    = instret_q;
  assign trap       = trap_q;
  assign trap_cause = cause_q;

endmodule

// File: doc/multicycle_ctrl_unit.md
Name: multicycle_ctrl_unit

Overview:
- Multi-cycle control path for the RV32I-subset core; successor to the single-cycle control unit.
- Sequences FETCH/DECODE/EXEC/MEM/WB across cycles so one shared memory port serves both instructions and data.
- Adds behaviour the single-cycle unit lacks:
  - ready-based memory handshake with bus timeout;
  - illegal-opcode trap;
  - retired-instruction counter.
- Sits beside the datapath inside the CPU top; its state and counter feed the debug output bus.

Parameters:
- ALU_OP_W, 4, width of alu_op
- TIMEOUT_W, 8, width of the memory-wait counter
- TIMEOUT_MAX, 255, wait cycles before a bus-timeout trap (must be at least 1)
- CNT_W, 32, width of the instret counter

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- opcode  in  7  instr[6:0] from the datapath instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- br_taken  in  1  datapath branch-condition result for the current EXEC
- mem_ready  in  1  memory completes the current request
- mem_req  out  1  memory request
- mem_we  out  1  write request
- addr_sel  out  1  0 = PC, 1 = ALU result
- ir_we  out  1  instruction register load
- pc_we  out  1  PC load
- pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target
- alu_op  out  ALU_OP_W  ALU function
- alu_src  out  1  0 = rs2, 1 = immediate
- reg_wr  out  1  register-file write
- wb_sel  out  2  0 = ALU, 1 = memory data, 2 = PC+4, 3 = immediate
- state_o  out  3  current state (debug)
- instret  out  CNT_W  retired-instruction count
- trap  out  1  sticky trap flag
- trap_cause  out  2  0 = none, 1 = illegal opcode, 2 = bus timeout

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset:
  - state <= FETCH; opcode/funct registers <= 0; wait counter, instret, trap, trap_cause <= 0.
  - While reset is high, all strobes (mem_req, mem_we, ir_we, pc_we, reg_wr) are forced to 0.
  - Reset mid-operation abandons the instruction with no retire.
- Registered inputs: opcode, funct3, funct7b5 are captured in DECODE. Control outputs are combinational from the registered state and these registered fields.
- Handshake:
  - mem_req holds high until mem_ready is sampled high.
  - mem_ready is ignored when mem_req = 0.
  - Wait counter increments on each cycle with mem_req = 1 and mem_ready = 0, and clears on handshake.
  - Counter reaching TIMEOUT_MAX -> TRAP, cause 2.
  - If mem_ready arrives in the same cycle the counter hits TIMEOUT_MAX, the handshake wins.
- FETCH: mem_req = 1, addr_sel = 0. On mem_ready: ir_we = 1, pc_we = 1, pc_src = 0, -> DECODE.
- DECODE: one cycle.
  - Opcode not in {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 0110111} -> TRAP, cause 1.
  - Otherwise -> EXEC.
- EXEC:
  - R-type: alu_src = 0, alu_op from funct3/funct7b5 -> WB.
  - I-ALU: alu_src = 1; funct7b5 is honoured only for funct3 = 101 (SRAI) -> WB.
  - LOAD/STORE: alu_src = 1, alu_op = ADD -> MEM.
  - BRANCH: alu_op = SUB for funct3 0/1, SLT for 4/5, SLTU for 6/7. If br_taken: pc_we = 1, pc_src = 1. Retire, -> FETCH.
  - JAL: pc_we = 1, pc_src = 2 -> WB.
  - LUI -> WB.
- MEM: mem_req = 1, addr_sel = 1, mem_we = 1 for STORE.
  - On mem_ready: STORE retires -> FETCH; LOAD -> WB.
- WB: reg_wr = 1; wb_sel = 1 for LOAD, 2 for JAL, 3 for LUI, else 0. Retire, -> FETCH.
- Retire: instret += 1, wrapping modulo 2^CNT_W.
- TRAP: terminal until reset; all strobes 0; trap = 1; trap_cause holds.
- Latencies: R/I/LUI/JAL = 4 cycles plus fetch wait; STORE = 4 plus waits; LOAD = 5 plus waits; BRANCH = 3 plus waits.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - state encodings: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, TRAP 5;
  - opcode constants;
  - ALU codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9;
  - pc_src, wb_sel and trap_cause codes.
- One sub-module, alu_op_decode: combinational mapping of opcode/funct3/funct7b5 to alu_op.

Test Plan:
- Reset, then ADD (0110011, f3 = 0, f7b5 = 0) with mem_ready = 1 every cycle -> states 0,1,2,4,0; alu_op = 0; reg_wr = 1 in WB; instret = 1.
- LW with mem_ready delayed 3 cycles in MEM -> mem_req held 4 cycles, addr_sel = 1, wb_sel = 1; instret increments only after WB.
- BEQ with br_taken = 1 -> pc_we = 1, pc_src = 1 in EXEC; back to FETCH after 3 states; no reg_wr.
- Opcode 1111111 -> TRAP in the cycle after DECODE; trap = 1, cause = 1; mem_req stays 0 for 20 cycles; reset -> FETCH.
- TIMEOUT_MAX = 4, mem_ready held 0 in FETCH -> TRAP, cause 2. Rerun with mem_ready arriving on the 4th wait cycle -> DECODE, no trap.
- Reset asserted during MEM of a store -> no further mem_we, instret unchanged, state FETCH on the next cycle.
